vending_change_dispenser: RTL and testbench

- Downstream payout unit for the vending controller.
- Consumes the controller's change amount (MO) and product code (PO) and physically pays out: one product-drop pulse, then one coin per cycle, largest denomination first.
- Tracks a finite coin stock per denomination and reports any change it could not pay.
- Sits between the vending controller outputs and the hopper/solenoid drivers.

---
 rtl/vending_change_dispenser.sv | 143 ++++++++++++++
 tb/tb_vending_change_dispenser.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_change_dispenser.sv
// Payout unit behind the vending controller: drops the product, then pays change
// one coin per cycle, largest denomination first, from a finite per-denomination stock.
module vending_change_dispenser #(
  parameter logic [7:0] COIN0      = 8'd50,
  parameter logic [7:0] COIN1      = 8'd10,
  parameter logic [7:0] COIN2      = 8'd5,
  parameter logic [7:0] COIN3      = 8'd1,
  parameter logic [7:0] STOCK_INIT = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] MO,
  input  logic [1:0] PO,
  input  logic       refill,
  output logic       busy,
  output logic [1:0] drop,
  output logic       coin_vld,
  output logic [1:0] coin,
  output logic       done,
  output logic       short,
  output logic [7:0] owed
);

  typedef enum logic [1:0] {IDLE, DROP, PAY, DONE} state_t;

  localparam logic [7:0] COIN_VAL [4] = '{COIN0, COIN1, COIN2, COIN3};

  state_t     state, state_n;
  logic [7:0] remain, remain_n;
  logic [7:0] stock [4];
  logic [7:0] stock_n [4];

  logic       busy_n, coin_vld_n, done_n, short_n;
  logic [1:0] drop_n, coin_n;
  logic [7:0] owed_n;

  logic       found;
  logic [1:0] sel;
  logic       try_pay, finish;

  // Lowest index wins: scan downwards so the last hit is the largest coin that fits.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (COIN_VAL[i] <= remain && stock[i] != 8'd0) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  // Outputs are registered, so each edge decides what the next cycle shows;
  // a coin is chosen at the edge that opens the PAY cycle presenting it.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    state_n    = state;
    remain_n   = remain;
    stock_n    = stock;
    busy_n     = 1'b0;
    drop_n     = 2'd0;
    coin_vld_n = 1'b0;
    coin_n     = 2'd0;
    done_n     = 1'b0;
    short_n    = 1'b0;
    owed_n     = 8'd0;
    try_pay    = 1'b0;
    finish     = 1'b0;

    case (state)
      IDLE: begin
        if (refill) begin
          for (int i = 0; i < 4; i++) stock_n[i] = STOCK_INIT;
        end
        if (PO != 2'd0) begin
          state_n  = DROP;
          remain_n = MO;
          busy_n   = 1'b1;
          drop_n   = PO;
        end
      end
      DROP: begin
        if (remain != 8'd0) try_pay = 1'b1;
        else                finish  = 1'b1;
      end
      // A PAY cycle without a coin is the stall: nothing more can be paid.
      PAY: begin
        if (coin_vld && remain != 8'd0) try_pay = 1'b1;
        else                            finish  = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (try_pay) begin
      state_n = PAY;
      busy_n  = 1'b1;
      if (found) begin
        coin_vld_n   = 1'b1;
        coin_n       = sel;
        remain_n     = remain - COIN_VAL[sel];
        stock_n[sel] = stock[sel] - 8'd1;
      end
    end

    if (finish) begin
      state_n = DONE;
      busy_n  = 1'b1;
      done_n  = 1'b1;
      short_n = (remain != 8'd0);
      owed_n  = remain;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      remain   <= 8'd0;
      // NOTE: the stock array is only four registers and must hold a known count after reset, so it is reset like any other state.
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
      busy     <= 1'b0;
      drop     <= 2'd0;
      coin_vld <= 1'b0;
      coin     <= 2'd0;
      done     <= 1'b0;
      short    <= 1'b0;
      owed     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state    <= state_n;
      remain   <= remain_n;
      stock    <= stock_n;
      busy     <= busy_n;
      drop     <= drop_n;
      coin_vld <= coin_vld_n;
      coin     <= coin_n;
      done     <= done_n;
      short    <= short_n;
      owed     <= owed_n;
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: two instances (stock 20 and stock 1) share stimulus;
// a per-cycle monitor pops expected busy-cycle records from a scoreboard queue per instance.
module tb_vending_change_dispenser;

  typedef struct packed {
    logic       busy;
    logic [1:0] drop;
    logic       coin_vld;
    logic [1:0] coin;
    logic       done;
    logic       short_f;
    logic [7:0] owed;
  } obs_t;

  localparam logic [7:0] COINS [4] = '{8'd50, 8'd10, 8'd5, 8'd1};
  localparam logic [7:0] INIT  [2] = '{8'd20, 8'd1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] MO = 8'd0;
  logic [1:0] PO = 2'd0;
  logic       refill = 1'b0;

  logic       busy0, coin_vld0, done0, short0;
  logic [1:0] drop0, coin0;
  logic [7:0] owed0;
  logic       busy1, coin_vld1, done1, short1;
  logic [1:0] drop1, coin1;
  logic [7:0] owed1;

  int checks = 0;
  int failures = 0;

  obs_t       q0[$];
  obs_t       q1[$];
  logic [7:0] ms [2][4];

  vending_change_dispenser dut0 (
    .clk(clk), .rst(rst), .MO(MO), .PO(PO), .refill(refill),
    .busy(busy0), .drop(drop0), .coin_vld(coin_vld0), .coin(coin0),
    .done(done0), .short(short0), .owed(owed0)
  );

  vending_change_dispenser #(.STOCK_INIT(8'd1)) dut1 (
    .clk(clk), .rst(rst), .MO(MO), .PO(PO), .refill(refill),
    .busy(busy1), .drop(drop1), .coin_vld(coin_vld1), .coin(coin1),
    .done(done1), .short(short1), .owed(owed1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t pk(input logic b, input logic [1:0] d, input logic cv,
                              input logic [1:0] c, input logic dn, input logic s,
                              input logic [7:0] ow);
    obs_t r;
    r.busy = b; r.drop = d; r.coin_vld = cv; r.coin = c;
    r.done = dn; r.short_f = s; r.owed = ow;
    return r;
  endfunction

  task automatic push(input int u, input obs_t r);
    if (u == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Reference payout: greedy largest-first from the model stock, stall then DONE if stuck.
  task automatic model_vend(input int u, input logic [7:0] mo, input logic [1:0] po, input logic rf);
    obs_t       r;
    logic [7:0] rem;
    int         s;
    if (rf) for (int i = 0; i < 4; i++) ms[u][i] = INIT[u];
    rem = mo;
    r = '0; r.busy = 1'b1; r.drop = po; push(u, r);
    while (rem != 8'd0) begin
      s = -1;
      for (int i = 3; i >= 0; i--) if (COINS[i] <= rem && ms[u][i] != 8'd0) s = i;
      r = '0; r.busy = 1'b1;
      if (s < 0) begin
        push(u, r);
        break;
      end
      r.coin_vld = 1'b1; r.coin = 2'(s);
      rem = rem - COINS[s];
      ms[u][s] = ms[u][s] - 8'd1;
      push(u, r);
    end
    r = '0; r.busy = 1'b1; r.done = 1'b1; r.short_f = (rem != 8'd0); r.owed = rem;
    push(u, r);
  endtask

  task automatic vend(input logic [7:0] mo, input logic [1:0] po, input logic rf, input int hold);
    @(negedge clk);
    MO = mo; PO = po; refill = rf;
    model_vend(0, mo, po, rf);
    model_vend(1, mo, po, rf);
    repeat (hold) @(negedge clk);
    MO = 8'd0; PO = 2'd0; refill = 1'b0;
  endtask

  task automatic check_stocks(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_stock_u0_%0d", tag, i), 32'(dut0.stock[i]), 32'(ms[0][i]));
      check($sformatf("%s_stock_u1_%0d", tag, i), 32'(dut1.stock[i]), 32'(ms[1][i]));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    check_stocks(tag);
  endtask

  always @(negedge clk) begin : mon
    obs_t o, e;
    o = pk(busy0, drop0, coin_vld0, coin0, done0, short0, owed0);
    e = '0;
    if (o.busy && q0.size() != 0) e = q0.pop_front();
    check("mon_u0", 32'(o), 32'(e));
    o = pk(busy1, drop1, coin_vld1, coin1, done1, short1, owed1);
    e = '0;
    if (o.busy && q1.size() != 0) e = q1.pop_front();
    check("mon_u1", 32'(o), 32'(e));
  end

  initial begin
    for (int u = 0; u < 2; u++) for (int i = 0; i < 4; i++) ms[u][i] = INIT[u];

    #1;
    check("reset_out_u0", 32'(pk(busy0, drop0, coin_vld0, coin0, done0, short0, owed0)), 32'd0);
    check("reset_out_u1", 32'(pk(busy1, drop1, coin_vld1, coin1, done1, short1, owed1)), 32'd0);
    repeat (2) @(negedge clk);
    check_stocks("reset");
    #1 rst = 1'b1;

    // 1: MO=75 -> 50,10,10,5 on the stock-20 unit
    vend(8'd75, 2'd2, 1'b0, 1);
    drain("s1");
    check("s1_stock0", 32'(dut0.stock[0]), 32'd19);
    check("s1_stock1", 32'(dut0.stock[1]), 32'd18);
    check("s1_stock2", 32'(dut0.stock[2]), 32'd19);
    check("s1_stock3", 32'(dut0.stock[3]), 32'd20);

    // 2: zero change -> drop then done, no coins
    vend(8'd0, 2'd1, 1'b0, 1);
    drain("s2");

    // 2b: PO held through DONE restarts on the first IDLE edge
    @(negedge clk);
    MO = 8'd0; PO = 2'd1;
    model_vend(0, 8'd0, 2'd1, 1'b0); model_vend(1, 8'd0, 2'd1, 1'b0);
    model_vend(0, 8'd0, 2'd1, 1'b0); model_vend(1, 8'd0, 2'd1, 1'b0);
    repeat (4) @(negedge clk);
    PO = 2'd0;
    drain("s2b");

    // 3: restart both units from full stock, then MO=17 (unit1 pays 10,5,1 and owes 1)
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 4; i++) ms[u][i] = INIT[u];
    #1 rst = 1'b1;
    vend(8'd17, 2'd3, 1'b0, 1);
    drain("s3");
    check("s3_u1_exhausted_stock3", 32'(dut1.stock[3]), 32'd0);
    vend(8'd1, 2'd1, 1'b0, 1);
    drain("s3b");

    // 4: refill alone in IDLE, then MO=6 -> 5,1
    @(negedge clk);
    refill = 1'b1;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 4; i++) ms[u][i] = INIT[u];
    @(negedge clk);
    refill = 1'b0;
    check_stocks("s4_refill");
    vend(8'd6, 2'd1, 1'b0, 1);
    drain("s4");

    // 4b: refill on the capture edge reloads before paying
    vend(8'd6, 2'd2, 1'b1, 1);
    drain("s4b");

    // 5: inputs disturbed during PAY are ignored, refill included
    vend(8'd75, 2'd2, 1'b0, 1);
    @(negedge clk);
    MO = 8'd200; PO = 2'd3; refill = 1'b1;
    @(negedge clk);
    MO = 8'd0; PO = 2'd0; refill = 1'b0;
    drain("s5");

    // 6: reset after the second coin aborts with no done pulse
    vend(8'd75, 2'd2, 1'b0, 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("s6_abort_u0", 32'(pk(busy0, drop0, coin_vld0, coin0, done0, short0, owed0)), 32'd0);
    check("s6_abort_u1", 32'(pk(busy1, drop1, coin_vld1, coin1, done1, short1, owed1)), 32'd0);
    q0.delete();
    q1.delete();
    for (int u = 0; u < 2; u++) for (int i = 0; i < 4; i++) ms[u][i] = INIT[u];
    repeat (2) @(negedge clk);
    check("s6_no_done", 32'(done0), 32'd0);
    check_stocks("s6_reset");
    #1 rst = 1'b1;
    vend(8'd75, 2'd2, 1'b0, 1);
    drain("s6");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
